// File: rtl/spart_driver.sv
`timescale 1ns/1ps
// spart_driver
//   Echo driver for a SPART UART core. After reset it programs the baud-rate
//   divisor, then continuously polls the SPART status register. Each received
//   byte is pushed into a small circular echo buffer. Each time the
//   transmitter is ready, the oldest buffered byte is written back out.
//   A change on br_cfg reprograms the divisor without flushing the buffer.
//
// Ports
//   clk        : system clock (50 MHz)
//   rst_n      : asynchronous active-low reset
//   br_cfg     : baud select (00=4800, 01=9600, 10=19200, 11=38400)
//   iocs       : SPART chip select, one clk per bus access
//   iorw       : 1 = read from SPART, 0 = write to SPART
//   ioaddr     : SPART register (00 data, 01 status, 10 DB low, 11 DB high)
//   databus    : shared bus, driven only while iocs=1 and iorw=0
//   rda, tbr   : SPART flags, observation only (polling uses the status read)
//   fifo_level : echo-buffer occupancy
module spart_driver #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    br_cfg,
  output logic                          iocs,
  output logic                          iorw,
  output logic [1:0]                    ioaddr,
  inout  wire  [7:0]                    databus,
  input  logic                          rda,
  input  logic                          tbr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {INIT_LO, INIT_HI, POLL, READ, WRITE} state_t;

  // round(50e6 / (16 * baud) - 1)
  function automatic logic [15:0] divisor_of(input logic [1:0] cfg);
    case (cfg)
      2'b00:   return 16'd650;
      2'b01:   return 16'd325;
      2'b10:   return 16'd162;
      default: return 16'd80;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic            active_q;     // low for the single edge after reset release
  logic            iocs_q, iorw_q;
  logic [1:0]      ioaddr_q;
  logic [7:0]      dout_q;
  logic [1:0]      cfg_meta_q, cfg_sync_q, cfg_prog_q;
  logic            pending_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   count_q;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic [15:0]     div_sync, div_prog;
  logic            fifo_full, fifo_empty, push, pop;
  logic            unused_flags;

  assign div_sync   = divisor_of(cfg_sync_q);
  assign div_prog   = divisor_of(cfg_prog_q);
  assign fifo_full  = (count_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = active_q && (state_q == READ);
  assign pop        = active_q && (state_q == WRITE);
  assign unused_flags = rda ^ tbr;

  // During POLL the SPART drives the status byte; it is decided on at the
  // closing edge. Outputs are registered, so databus never reaches the pins.
  always_comb begin
    state_d = state_q;
    if (!active_q) begin
      state_d = INIT_LO;
    end else begin
      case (state_q)
        INIT_LO: state_d = INIT_HI;
        INIT_HI: state_d = POLL;
        POLL: begin
          if (pending_q)                       state_d = INIT_LO;
          else if (databus[0] && !fifo_full)   state_d = READ;
          else if (databus[1] && !fifo_empty)  state_d = WRITE;
          else                                 state_d = POLL;
        end
        READ, WRITE: state_d = POLL;
        default:     state_d = INIT_LO;
      endcase
    end
  end

  // FSM state plus registered bus outputs, loaded for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT_LO;
      active_q   <= 1'b0;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= 2'b00;
      dout_q     <= 8'h00;
      cfg_meta_q <= 2'b01;
      cfg_sync_q <= 2'b01;
      cfg_prog_q <= 2'b01;
      pending_q  <= 1'b0;
    end else begin
      cfg_meta_q <= br_cfg;
      cfg_sync_q <= cfg_meta_q;
      active_q   <= 1'b1;
      state_q    <= state_d;

      // Entering INIT_LO latches the value being programmed.
      if (state_d == INIT_LO) begin
        cfg_prog_q <= cfg_sync_q;
        pending_q  <= 1'b0;
      end else if (cfg_sync_q != cfg_prog_q) begin
        pending_q  <= 1'b1;
      end

      iocs_q <= 1'b1;
      case (state_d)
        INIT_LO: begin iorw_q <= 1'b0; ioaddr_q <= 2'b10; dout_q <= div_sync[7:0];  end
        INIT_HI: begin iorw_q <= 1'b0; ioaddr_q <= 2'b11; dout_q <= div_prog[15:8]; end
        POLL:    begin iorw_q <= 1'b1; ioaddr_q <= 2'b01; end
        READ:    begin iorw_q <= 1'b1; ioaddr_q <= 2'b00; end
        WRITE:   begin iorw_q <= 1'b0; ioaddr_q <= 2'b00; dout_q <= mem_q[rd_ptr_q]; end
        default: begin iocs_q <= 1'b0; iorw_q <= 1'b1; ioaddr_q <= 2'b00; end
      endcase
    end
  end

  // Echo buffer bookkeeping; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // READ is only entered when not full, so push never overruns.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= databus;
  end

  assign iocs       = iocs_q;
  assign iorw       = iorw_q;
  assign ioaddr     = ioaddr_q;
  assign fifo_level = count_q;
  assign databus    = (iocs_q && !iorw_q) ? dout_q : 8'bz;

endmodule
